// File: rtl/vga_escalonador_frota.sv
// ---------------------------------------------------------------------------
// vga_escalonador_frota
//   Fleet draw scheduler for the 8x8 naval map on the 640x480 VGA path.
//   On each fim_quadro pulse a fetch FSM reads every ship cell from game
//   memory over a req/ack handshake into shadow registers. During blanking
//   the shadow set is copied to the active set. The active set is painted
//   per pixel with a fixed colour per ship; the lowest ship index wins.
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     fim_quadro          1-cycle pulse at the end of the visible frame
//     areaAtiva           active video area
//     linha, coluna       current pixel row / column (10 bits)
//     mem_req, mem_idx    read request and {ship[2:0], cell[1:0]} index
//     mem_ack, mem_dado   read strobe and cell data {Y[7:4], X[3:0]}
//     rgb_r/g/b           registered pixel colour
//     carregando          high while the fetch FSM is busy
//     quadro_pronto       1-cycle pulse when the shadow->active swap happens
//
//   Build option
//     VGA_ESCALONADOR_GRADE_EN : draws white grid lines in the gaps between
//     map cells (ships still on top). Undefined: gaps stay black.
// ---------------------------------------------------------------------------
module vga_escalonador_frota #(
   parameter int NUM_NAVIOS = 5,
   parameter int CELULAS    = 4,
   parameter int TIMEOUT    = 15,
   parameter int LARGURA    = 54,
   parameter int ALTURA     = 49,
   parameter int PASSO_X    = 62,
   parameter int PASSO_Y    = 57,
   parameter int ORIGEM     = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fim_quadro,
   input  logic       areaAtiva,
   input  logic [9:0] linha,
   input  logic [9:0] coluna,
   output logic       mem_req,
   output logic [4:0] mem_idx,
   input  logic       mem_ack,
   input  logic [7:0] mem_dado,
   output logic       rgb_r,
   output logic       rgb_g,
   output logic       rgb_b,
   output logic       carregando,
   output logic       quadro_pronto
);

   localparam int NCELL = NUM_NAVIOS * CELULAS;

   typedef enum logic [1:0] {OCIOSO, PEDE, TROCA} estado_t;

   estado_t    state_reg, state_next;
   logic       req_reg, req_next;
   logic [4:0] idx_reg, idx_next;
   logic [3:0] timer_reg, timer_next;
   logic       pronto_reg;
   logic [2:0] rgb_reg;

   // grava: the current cell is finished (ack or timeout) and is written
   // into its shadow slot; troca: shadow set is copied to the active set.
   logic       grava;
   logic       troca;
   logic       dado_valido;

   logic [NCELL-1:0]      acerto;
   logic [NUM_NAVIOS-1:0] navio_acerto;
   logic [2:0]            cor;

   // A cell is present only when both coordinates lie in 1..8 and the data
   // really arrived (a timeout stores the cell as absent).
   assign dado_valido = mem_ack
                        && (mem_dado[3:0] != 4'd0) && (mem_dado[3:0] <= 4'd8)
                        && (mem_dado[7:4] != 4'd0) && (mem_dado[7:4] <= 4'd8);

   // ---------------- fetch FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= OCIOSO;
         req_reg    <= 1'b0;
         idx_reg    <= 5'd0;
         timer_reg  <= 4'd0;
         pronto_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         req_reg    <= req_next;
         idx_reg    <= idx_next;
         timer_reg  <= timer_next;
         pronto_reg <= troca;
      end
   end

   always_comb begin
      state_next = state_reg;
      req_next   = req_reg;
      idx_next   = idx_reg;
      timer_next = timer_reg;
      grava      = 1'b0;
      troca      = 1'b0;
      case (state_reg)
         OCIOSO: begin
            if (fim_quadro) begin
               state_next = PEDE;
               idx_next   = 5'd0;
            end
         end
         PEDE: begin
            if (!req_reg) begin
               // First cycle of each cell: raise the request, restart timer.
               req_next   = 1'b1;
               timer_next = 4'd0;
            end else if (mem_ack || (timer_reg == 4'(TIMEOUT - 1))) begin
               // Ack is checked first so an ack on the last allowed cycle
               // still counts; acks outside req_reg are never looked at.
               grava    = 1'b1;
               req_next = 1'b0;
               if (idx_reg == 5'(NCELL - 1)) begin
                  state_next = TROCA;
                  idx_next   = 5'd0;
               end else begin
                  idx_next = idx_reg + 5'd1;
               end
            end else begin
               timer_next = timer_reg + 4'd1;
            end
         end
         TROCA: begin
            // Swap only in blanking so a line is never drawn from two sets.
            if (!areaAtiva) begin
               troca      = 1'b1;
               state_next = OCIOSO;
            end
         end
         default: state_next = OCIOSO;
      endcase
   end

   assign mem_req       = req_reg;
   assign mem_idx       = idx_reg;
   assign carregando    = (state_reg != OCIOSO);
   assign quadro_pronto = pronto_reg;

   // ---------------- per-cell shadow/active storage and hit test ----------------
   genvar gi;
   generate
      for (gi = 0; gi < NCELL; gi++) begin : g_celula
         logic       sombra_v_reg, ativo_v_reg;
         logic [3:0] sombra_x_reg, sombra_y_reg, ativo_x_reg, ativo_y_reg;
         logic [9:0] esq, inf;

         always_ff @(posedge clk) begin
            if (rst) begin
               sombra_v_reg <= 1'b0;
               sombra_x_reg <= 4'd0;
               sombra_y_reg <= 4'd0;
               ativo_v_reg  <= 1'b0;
               ativo_x_reg  <= 4'd0;
               ativo_y_reg  <= 4'd0;
            end else begin
               if (grava && (idx_reg == 5'(gi))) begin
                  sombra_v_reg <= dado_valido;
                  sombra_x_reg <= mem_dado[3:0];
                  sombra_y_reg <= mem_dado[7:4];
               end
               if (troca) begin
                  ativo_v_reg <= sombra_v_reg;
                  ativo_x_reg <= sombra_x_reg;
                  ativo_y_reg <= sombra_y_reg;
               end
            end
         end

         assign esq = 10'(ORIGEM) + (10'(ativo_x_reg) - 10'd1) * 10'(PASSO_X);
         assign inf = 10'(ORIGEM) + (10'(ativo_y_reg) - 10'd1) * 10'(PASSO_Y);

         // Strict on both edges: the cell border pixels are not painted.
         assign acerto[gi] = ativo_v_reg
                             && (coluna > esq) && (coluna < esq + 10'(LARGURA))
                             && (linha  > inf) && (linha  < inf + 10'(ALTURA));
      end

      for (gi = 0; gi < NUM_NAVIOS; gi++) begin : g_navio
         assign navio_acerto[gi] = |acerto[gi*CELULAS +: CELULAS];
      end
   endgenerate

`ifdef VGA_ESCALONADOR_GRADE_EN
   // ---------------- grid lines in the gaps between map cells ----------------
   localparam int MAPA_X_MAX = ORIGEM + 8 * PASSO_X - 1;
   localparam int MAPA_Y_MAX = ORIGEM + 8 * PASSO_Y - 1;

   logic [7:0] dentro_col, dentro_lin;
   logic       grade;

   generate
      for (gi = 0; gi < 8; gi++) begin : g_grade
         assign dentro_col[gi] = (coluna > 10'(ORIGEM + gi * PASSO_X))
                                 && (coluna < 10'(ORIGEM + gi * PASSO_X + LARGURA));
         assign dentro_lin[gi] = (linha > 10'(ORIGEM + gi * PASSO_Y))
                                 && (linha < 10'(ORIGEM + gi * PASSO_Y + ALTURA));
      end
   endgenerate

   assign grade = (coluna >= 10'(ORIGEM)) && (coluna <= 10'(MAPA_X_MAX))
                  && (linha >= 10'(ORIGEM)) && (linha <= 10'(MAPA_Y_MAX))
                  && (!(|dentro_col) || !(|dentro_lin));
`endif

   function automatic logic [2:0] paleta(input int navio);
      case (navio)
         0:       paleta = 3'b010;  // Submarino, green
         1:       paleta = 3'b100;  // Cruzador, red
         2:       paleta = 3'b110;  // Hidroaviao, yellow
         3:       paleta = 3'b101;  // Encouracado, violet
         4:       paleta = 3'b011;  // Porta-avioes, cyan
         default: paleta = 3'b111;
      endcase
   endfunction

   // Walk from the highest index down so the lowest hitting ship is last
   // to assign and therefore wins.
   always_comb begin
`ifdef VGA_ESCALONADOR_GRADE_EN
      cor = grade ? 3'b111 : 3'b000;
`else
      cor = 3'b000;
`endif
      for (int s = NUM_NAVIOS - 1; s >= 0; s--) begin
         if (navio_acerto[s]) begin
            cor = paleta(s);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_reg <= 3'b000;
      end else if (!areaAtiva) begin
         rgb_reg <= 3'b000;
      end else begin
         rgb_reg <= cor;
      end
   end

   assign rgb_r = rgb_reg[2];
   assign rgb_g = rgb_reg[1];
   assign rgb_b = rgb_reg[0];

endmodule

// File: tb/tb_vga_escalonador_frota.sv
// ---------------------------------------------------------------------------
// tb_vga_escalonador_frota
//   Self-checking bench for vga_escalonador_frota: directed table vectors,
//   hand-written multi-cycle sequences (timeout, delayed swap, reset
//   mid-fetch) and randomized fetches checked against a fleet model.
// ---------------------------------------------------------------------------
module tb_vga_escalonador_frota;

   logic       clk = 1'b0;
   logic       rst, fim_quadro, areaAtiva;
   logic [9:0] linha, coluna;
   logic       mem_req, mem_ack;
   logic [4:0] mem_idx;
   logic [7:0] mem_dado;
   logic       rgb_r, rgb_g, rgb_b, carregando, quadro_pronto;

   vga_escalonador_frota dut (
      .clk(clk), .rst(rst), .fim_quadro(fim_quadro), .areaAtiva(areaAtiva),
      .linha(linha), .coluna(coluna), .mem_req(mem_req), .mem_idx(mem_idx),
      .mem_ack(mem_ack), .mem_dado(mem_dado), .rgb_r(rgb_r), .rgb_g(rgb_g),
      .rgb_b(rgb_b), .carregando(carregando), .quadro_pronto(quadro_pronto)
   );

   always #5 clk = ~clk;

   wire [2:0] rgb = {rgb_r, rgb_g, rgb_b};

   int n_cmp = 0;
   int n_bad = 0;

   // Memory contents and responder control
   logic [7:0] mem_tbl [20];
   bit         accepted [20];
   int         ack_mode = 0;   // 0: ack after 1 cycle, 1: never, 2: random 1..18
   bit         stray_en = 0;
   int         req_log[$];
   int         dur_log[$];

   // Model of the fleet currently on screen
   int mx [20];
   int my [20];
   bit mv [20];

   typedef struct {
      logic [9:0] l;
      logic [9:0] c;
      logic       a;
      logic [2:0] exp_base;
      logic [2:0] exp_grade;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Memory responder: counts how long each request has been visible and
   // acks when the drawn delay is reached; a request that exceeds the
   // 15-cycle window is never acked.
   initial begin
      int hi;
      int target;
      hi = 0;
      target = 1;
      mem_ack = 1'b0;
      mem_dado = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         mem_dado = 8'($urandom);
         if (mem_req === 1'b1) begin
            if (hi == 0) begin
               case (ack_mode)
                  0: target = 1;
                  1: target = 1000;
                  default: target = int'($urandom_range(1, 18));
               endcase
               req_log.push_back(int'(mem_idx));
            end
            hi++;
            if (hi == target) begin
               mem_ack = 1'b1;
               mem_dado = mem_tbl[mem_idx];
               accepted[mem_idx] = 1'b1;
            end
         end else begin
            if (hi != 0) dur_log.push_back(hi);
            hi = 0;
            if (stray_en && ($urandom_range(0, 3) == 0)) begin
               mem_ack = 1'b1;
            end
         end
      end
   end

   // Reference pixel: first valid ship cell (ships in index order) whose
   // open rectangle contains the pixel decides the colour.
   function automatic logic [2:0] ref_rgb(input int l, input int c, input bit a);
      logic [2:0] cores [5];
      cores[0] = 3'b010; cores[1] = 3'b100; cores[2] = 3'b110;
      cores[3] = 3'b101; cores[4] = 3'b011;
      if (!a) return 3'b000;
      for (int i = 0; i < 20; i++) begin
         if (mv[i]) begin
            int esq, inf;
            esq = 16 + (mx[i] - 1) * 62;
            inf = 16 + (my[i] - 1) * 57;
            if (c > esq && c < esq + 54 && l > inf && l < inf + 49) return cores[i / 4];
         end
      end
`ifdef VGA_ESCALONADOR_GRADE_EN
      if (c >= 16 && c <= 511 && l >= 16 && l <= 471) begin
         bit cg, lg;
         cg = 1; lg = 1;
         for (int g = 0; g < 8; g++) begin
            if (c > 16 + g * 62 && c < 16 + g * 62 + 54) cg = 0;
            if (l > 16 + g * 57 && l < 16 + g * 57 + 49) lg = 0;
         end
         if (cg || lg) return 3'b111;
      end
`endif
      return 3'b000;
   endfunction

   function automatic void model_swap();
      for (int i = 0; i < 20; i++) begin
         int x, y;
         x = int'(mem_tbl[i][3:0]);
         y = int'(mem_tbl[i][7:4]);
         mx[i] = x;
         my[i] = y;
         mv[i] = accepted[i] && x >= 1 && x <= 8 && y >= 1 && y <= 8;
      end
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 20; i++) mv[i] = 1'b0;
   endfunction

   task automatic pix(input string name, input int l, input int c, input bit a,
                      input logic [2:0] exp);
      linha = 10'(l);
      coluna = 10'(c);
      areaAtiva = a;
      @(posedge clk);
      #1;
      $display("pixel %s l=%0d c=%0d a=%0d", name, l, c, a);
      chk(name, 32'(rgb), 32'(exp));
   endtask

   task automatic pix_model(input string name, input int l, input int c, input bit a);
      pix(name, l, c, a, ref_rgb(l, c, a));
   endtask

   // Pulse fim_quadro and wait (bounded) for quadro_pronto; n is the number
   // of edges after the pulse edge until the pulse is visible.
   task automatic run_fetch(input int max, output int n);
      for (int i = 0; i < 20; i++) accepted[i] = 1'b0;
      req_log.delete();
      dur_log.delete();
      areaAtiva = 1'b0;
      fim_quadro = 1'b1;
      @(posedge clk);
      #1;
      fim_quadro = 1'b0;
      n = 0;
      while (quadro_pronto !== 1'b1 && n < max) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("pronto_visto", 32'(quadro_pronto), 32'd1);
      model_swap();
      $display("fetch done after %0d cycles, %0d requests", n, req_log.size());
   endtask

   function automatic void mem_zero();
      for (int i = 0; i < 20; i++) mem_tbl[i] = 8'h00;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   initial begin
      vec_t vt2 [6];
      vec_t vt3 [4];
      int   n, bad;
      bit   seen;

      vt2[0] = '{10'd20, 10'd20, 1'b1, 3'b010, 3'b010};
      vt2[1] = '{10'd16, 10'd20, 1'b1, 3'b000, 3'b111};
      vt2[2] = '{10'd20, 10'd16, 1'b1, 3'b000, 3'b111};
      vt2[3] = '{10'd64, 10'd69, 1'b1, 3'b010, 3'b010};
      vt2[4] = '{10'd65, 10'd20, 1'b1, 3'b000, 3'b111};
      vt2[5] = '{10'd20, 10'd20, 1'b0, 3'b000, 3'b000};
      vt3[0] = '{10'd80, 10'd150, 1'b1, 3'b100, 3'b100};
      vt3[1] = '{10'd74, 10'd141, 1'b1, 3'b100, 3'b100};
      vt3[2] = '{10'd73, 10'd150, 1'b1, 3'b000, 3'b111};
      vt3[3] = '{10'd20, 10'd20, 1'b1, 3'b010, 3'b010};

      mem_zero();
      model_clear();
      linha = 10'd0;
      coluna = 10'd0;
      areaAtiva = 1'b0;

      // 1. Reset with fim_quadro held high
      rst = 1'b1;
      fim_quadro = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rgb", 32'(rgb), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_idx", 32'(mem_idx), 32'd0);
      chk("rst_carregando", 32'(carregando), 32'd0);
      chk("rst_pronto", 32'(quadro_pronto), 32'd0);
      rst = 1'b0;
      fim_quadro = 1'b0;
      @(posedge clk);
      #1;
      chk("fim_em_rst_ignorado", 32'(carregando), 32'd0);

      // 2. Single cell, 1-cycle acks
      mem_tbl[0] = 8'h11;
      ack_mode = 0;
      run_fetch(200, n);
      chk("ciclos_carga_ack1", 32'(n), 32'd41);
      chk("n_pedidos", 32'(req_log.size()), 32'd20);
      bad = 0;
      foreach (req_log[i]) if (req_log[i] != i) bad++;
      chk("ordem_idx", 32'(bad), 32'd0);
      chk("ocioso_apos_troca", 32'(carregando), 32'd0);
      for (int i = 0; i < 6; i++) begin
`ifdef VGA_ESCALONADOR_GRADE_EN
         pix($sformatf("t2_vec%0d", i), int'(vt2[i].l), int'(vt2[i].c), vt2[i].a, vt2[i].exp_grade);
`else
         pix($sformatf("t2_vec%0d", i), int'(vt2[i].l), int'(vt2[i].c), vt2[i].a, vt2[i].exp_base);
`endif
      end

      // 3. Overlapping ships 1 and 3: lower index wins
      mem_tbl[4] = 8'h23;
      mem_tbl[12] = 8'h23;
      run_fetch(200, n);
      for (int i = 0; i < 4; i++) begin
`ifdef VGA_ESCALONADOR_GRADE_EN
         pix($sformatf("t3_vec%0d", i), int'(vt3[i].l), int'(vt3[i].c), vt3[i].a, vt3[i].exp_grade);
`else
         pix($sformatf("t3_vec%0d", i), int'(vt3[i].l), int'(vt3[i].c), vt3[i].a, vt3[i].exp_base);
`endif
      end

      // 4. Memory never answers: every cell times out after 15 cycles
      ack_mode = 1;
      run_fetch(1000, n);
      chk("ciclos_timeout", 32'(n), 32'd321);
      chk("n_timeouts", 32'(dur_log.size()), 32'd20);
      bad = 0;
      foreach (dur_log[i]) if (dur_log[i] != 15) bad++;
      chk("req_alto_15", 32'(bad), 32'd0);
      pix("t4_vazio_navio1", 80, 150, 1'b1, 3'b000);
      pix("t4_vazio_navio0", 20, 20, 1'b1, 3'b000);

      // 5. Fetch completes during active video: swap waits for blanking
      ack_mode = 0;
      mem_zero();
      mem_tbl[0] = 8'h11;
      for (int i = 0; i < 20; i++) accepted[i] = 1'b0;
      linha = 10'd20;
      coluna = 10'd20;
      areaAtiva = 1'b1;
      fim_quadro = 1'b1;
      @(posedge clk);
      #1;
      fim_quadro = 1'b0;
      seen = 0;
      repeat (60) begin
         @(posedge clk);
         #1;
         if (quadro_pronto === 1'b1) seen = 1;
      end
      chk("t5_sem_pronto_em_video", 32'(seen), 32'd0);
      chk("t5_espera_troca", 32'(carregando), 32'd1);
      chk("t5_imagem_antiga", 32'(rgb), 32'd0);
      areaAtiva = 1'b0;
      @(posedge clk);
      #1;
      chk("t5_pronto_no_blank", 32'(quadro_pronto), 32'd1);
      model_swap();
      pix_model("t5_imagem_nova", 20, 20, 1'b1);

      // 6. Reset in the middle of a fetch
      mem_tbl[5] = 8'h45;
      for (int i = 0; i < 20; i++) accepted[i] = 1'b0;
      areaAtiva = 1'b0;
      fim_quadro = 1'b1;
      @(posedge clk);
      #1;
      fim_quadro = 1'b0;
      n = 0;
      while (!(mem_req === 1'b1 && mem_idx === 5'd7) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("t6_chegou_idx7", 32'(mem_idx), 32'd7);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t6_req_caiu", 32'(mem_req), 32'd0);
      chk("t6_carregando", 32'(carregando), 32'd0);
      model_clear();
      pix("t6_ativo_limpo", 20, 20, 1'b1, 3'b000);
      run_fetch(200, n);
      chk("t6_reinicio_idx0", 32'(req_log.size() > 0 ? req_log[0] : -1), 32'd0);
      pix_model("t6_recarga", 20, 20, 1'b1);
      pix_model("t6_grade", 60, 75, 1'b1);

      // Randomized fetches with random ack latency and stray acks
      ack_mode = 2;
      stray_en = 1;
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) mem_tbl[i] = 8'($urandom);
            else mem_tbl[i] = {4'($urandom_range(1, 8)), 4'($urandom_range(1, 8))};
         end
         run_fetch(1000, n);
         for (int k = 0; k < 30; k++) begin
            int l, c, i, x, y;
            bit a;
            i = int'($urandom_range(0, 19));
            x = int'(mem_tbl[i][3:0]);
            y = int'(mem_tbl[i][7:4]);
            a = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 1 && x >= 1 && x <= 8 && y >= 1 && y <= 8) begin
               c = 16 + (x - 1) * 62 + int'($urandom_range(0, 54));
               l = 16 + (y - 1) * 57 + int'($urandom_range(0, 49));
            end else begin
               c = int'($urandom_range(0, 639));
               l = int'($urandom_range(0, 479));
            end
            pix_model($sformatf("rnd%0d_%0d", r, k), l, c, a);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
